// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes and state encodings for the CPU run/halt/step controller.
package cpu_ctrl_pkg;

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10
  } state_t;

endpackage

// File: rtl/cycle_counter.sv
// Free-running counter of enabled core cycles; wraps, never saturates.
module cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear wins over increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step controller producing the per-cycle core clock enable.
module cpu_clock_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              bp_enable,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic [PC_W-1:0]   pc,
  input  logic              core_halt_req,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic [STEP_W-1:0] steps_left,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              bp_hit,
  output logic              core_halted,
  output logic              done_pulse
);

  localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_next;
  logic [STEP_W-1:0] steps_r, steps_next;
  logic              bp_hit_r, bp_hit_next;
  logic              core_halted_r, core_halted_next;
  logic              done_r, done_next;
  logic              skip_r, skip_next;
  logic              count_clear;
  logic              running;
  logic              halt_cmd;
  logic              bp_match;

  assign running   = (state_r != ST_HALTED);
  assign halt_cmd  = cmd_valid && (cmd_op == OP_HALT);
  assign bp_match  = bp_enable && (pc == bp_addr);
  assign cmd_ready = (state_r == ST_HALTED) || (cmd_op == OP_HALT);
  // skip_r lets the first enabled cycle execute the instruction sitting on a breakpoint
  assign cpu_en    = running && !halt_cmd && !core_halt_req && !(bp_match && !skip_r);

  // Next-state: command acceptance while halted, stop arbitration while running
  always_comb begin
    state_next       = state_r;
    steps_next       = steps_r;
    bp_hit_next      = bp_hit_r;
    core_halted_next = core_halted_r;
    done_next        = 1'b0;
    skip_next        = skip_r;
    count_clear      = 1'b0;
    if (state_r == ST_HALTED) begin
      if (cmd_valid) begin
        case (cmd_op)
          OP_RUN: begin
            state_next       = ST_RUN;
            steps_next       = STEP_ZERO;
            skip_next        = 1'b1;
            bp_hit_next      = 1'b0;
            core_halted_next = 1'b0;
          end
          OP_STEP: begin
            bp_hit_next      = 1'b0;
            core_halted_next = 1'b0;
            if (cmd_steps == STEP_ZERO) begin
              done_next = 1'b1;
            end else begin
              state_next = ST_STEP;
              steps_next = cmd_steps;
              skip_next  = 1'b1;
            end
          end
          OP_CLEAR: begin
            count_clear      = 1'b1;
            bp_hit_next      = 1'b0;
            core_halted_next = 1'b0;
          end
          default: begin
          end
        endcase
      end else begin
      end
    end else begin
      if (cpu_en) begin
        skip_next = 1'b0;
      end else begin
        skip_next = skip_r;
      end
      // Stop sources in priority order; step exhaustion only when the core actually advanced
      if (halt_cmd) begin
        state_next = ST_HALTED;
        done_next  = 1'b1;
      end else if (core_halt_req) begin
        state_next       = ST_HALTED;
        core_halted_next = 1'b1;
        done_next        = 1'b1;
      end else if (bp_match && !skip_r) begin
        state_next  = ST_HALTED;
        bp_hit_next = 1'b1;
        done_next   = 1'b1;
      end else if (state_r == ST_STEP) begin
        if (steps_r == STEP_ONE) begin
          state_next = ST_HALTED;
          steps_next = STEP_ZERO;
          done_next  = 1'b1;
        end else begin
          steps_next = steps_r - STEP_ONE;
        end
      end else begin
      end
    end
  end

  // Controller state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_HALTED;
      steps_r       <= STEP_ZERO;
      bp_hit_r      <= 1'b0;
      core_halted_r <= 1'b0;
      done_r        <= 1'b0;
      skip_r        <= 1'b0;
    end else begin
      state_r       <= state_next;
      steps_r       <= steps_next;
      bp_hit_r      <= bp_hit_next;
      core_halted_r <= core_halted_next;
      done_r        <= done_next;
      skip_r        <= skip_next;
    end
  end

  cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (count_clear),
    .enable (cpu_en),
    .count  (cycle_count)
  );

  assign state       = state_r;
  assign steps_left  = steps_r;
  assign bp_hit      = bp_hit_r;
  assign core_halted = core_halted_r;
  assign done_pulse  = done_r;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with a cycle-level behavioural model compared every cycle.
module tb_cpu_clock_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_steps;
  logic        bp_enable;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        core_halt_req;
  logic        cpu_en;
  logic [1:0]  state;
  logic [15:0] steps_left;
  logic [31:0] cycle_count;
  logic        bp_hit;
  logic        core_halted;
  logic        done_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Model: mode 0 halted, 1 free run, 2 stepping
  int          m_mode;
  logic [15:0] m_steps;
  logic [31:0] m_count;
  bit          m_bp, m_core, m_done, m_skip;

  cpu_clock_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_steps     (cmd_steps),
    .bp_enable     (bp_enable),
    .bp_addr       (bp_addr),
    .pc            (pc),
    .core_halt_req (core_halt_req),
    .cpu_en        (cpu_en),
    .state         (state),
    .steps_left    (steps_left),
    .cycle_count   (cycle_count),
    .bp_hit        (bp_hit),
    .core_halted   (core_halted),
    .done_pulse    (done_pulse)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_bp_stop();
    return bp_enable && (pc == bp_addr) && !m_skip;
  endfunction

  function automatic bit m_en();
    return (m_mode != 0) && !(cmd_valid && cmd_op == 2'b00) && !core_halt_req && !m_bp_stop();
  endfunction

  task automatic model_reset();
    m_mode = 0; m_steps = 16'd0; m_count = 32'd0;
    m_bp = 1'b0; m_core = 1'b0; m_done = 1'b0; m_skip = 1'b0;
  endtask

  task automatic model_edge();
    bit en, bstop;
    int prev;
    en = m_en();
    bstop = m_bp_stop();
    prev = m_mode;
    m_done = 1'b0;
    if (m_mode == 0) begin
      if (cmd_valid && cmd_op == 2'b01) begin
        m_mode = 1; m_steps = 16'd0; m_skip = 1'b1; m_bp = 1'b0; m_core = 1'b0;
      end else if (cmd_valid && cmd_op == 2'b10) begin
        m_bp = 1'b0; m_core = 1'b0;
        if (cmd_steps == 16'd0) m_done = 1'b1;
        else begin m_mode = 2; m_steps = cmd_steps; m_skip = 1'b1; end
      end else if (cmd_valid && cmd_op == 2'b11) begin
        m_count = 32'd0; m_bp = 1'b0; m_core = 1'b0;
      end
    end else begin
      if (en) begin m_count = m_count + 32'd1; m_skip = 1'b0; end
      if (cmd_valid && cmd_op == 2'b00) m_mode = 0;
      else if (core_halt_req) begin m_mode = 0; m_core = 1'b1; end
      else if (bstop) begin m_mode = 0; m_bp = 1'b1; end
      else if (m_mode == 2) begin
        m_steps = m_steps - 16'd1;
        if (m_steps == 16'd0) m_mode = 0;
      end
    end
    if (prev != 0 && m_mode == 0) m_done = 1'b1;
  endtask

  task automatic compare_model();
    check("cpu_en",      {63'd0, cpu_en},      {63'd0, m_en()});
    check("cmd_ready",   {63'd0, cmd_ready},   {63'd0, (m_mode == 0) || (cmd_op == 2'b00)});
    check("state",       {62'd0, state},       64'(m_mode));
    check("steps_left",  {48'd0, steps_left},  {48'd0, m_steps});
    check("cycle_count", {32'd0, cycle_count}, {32'd0, m_count});
    check("bp_hit",      {63'd0, bp_hit},      {63'd0, m_bp});
    check("core_halted", {63'd0, core_halted}, {63'd0, m_core});
    check("done_pulse",  {63'd0, done_pulse},  {63'd0, m_done});
  endtask

  // One clock cycle: compare before the edge, advance the model on the edge, return at negedge
  task automatic cyc();
    #2;
    compare_model();
    @(posedge clock);
    model_edge();
    cyc_n++;
    @(negedge clock);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] n);
    cmd_valid = 1'b1; cmd_op = op; cmd_steps = n;
  endtask

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_steps = 16'd0;
    bp_enable = 1'b0; bp_addr = 32'd0; pc = 32'd0; core_halt_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_cpu_en", {63'd0, cpu_en}, 64'd0);
    check("rst_count", {32'd0, cycle_count}, 64'd0);
    check("rst_done", {63'd0, done_pulse}, 64'd0);
    reset = 1'b0;
    cyc_n = 0;

    // RUN at cycle 5, HALT at cycle 20
    while (cyc_n < 5) cyc();
    cmd(2'b01, 16'd0);
    cyc();
    cmd_valid = 1'b0;
    #1 check("run_en_c6", {63'd0, cpu_en}, 64'd1);
    while (cyc_n < 20) cyc();
    cmd(2'b00, 16'd0);
    #1 check("halt_en_c20", {63'd0, cpu_en}, 64'd0);
    cyc();
    cmd_valid = 1'b0;
    check("count_14", {32'd0, cycle_count}, 64'd14);
    check("done_c21", {63'd0, done_pulse}, 64'd1);
    cyc();
    check("done_once", {63'd0, done_pulse}, 64'd0);

    // STEP 3 then STEP 0
    cmd(2'b10, 16'd3);
    cyc();
    cmd_valid = 1'b0;
    check("step3_left3", {48'd0, steps_left}, 64'd3);
    for (int i = 2; i >= 0; i--) begin
      #1 check("step3_en", {63'd0, cpu_en}, 64'd1);
      cyc();
      check("step3_left", {48'd0, steps_left}, 64'(i));
    end
    check("step3_done", {63'd0, done_pulse}, 64'd1);
    check("step3_count", {32'd0, cycle_count}, 64'd17);
    cyc();
    cmd(2'b10, 16'd0);
    #1 check("step0_en", {63'd0, cpu_en}, 64'd0);
    cyc();
    cmd_valid = 1'b0;
    check("step0_done", {63'd0, done_pulse}, 64'd1);
    check("step0_state", {62'd0, state}, 64'd0);
    cyc();

    // Breakpoint at 0x40 and resume from it
    bp_enable = 1'b1; bp_addr = 32'h40; pc = 32'h38;
    cmd(2'b01, 16'd0);
    cyc();
    cmd_valid = 1'b0;
    cyc(); pc = 32'h3C;
    cyc(); pc = 32'h40;
    #1 check("bp_en_low", {63'd0, cpu_en}, 64'd0);
    cyc();
    check("bp_hit_set", {63'd0, bp_hit}, 64'd1);
    check("bp_state", {62'd0, state}, 64'd0);
    cmd(2'b01, 16'd0);
    cyc();
    cmd_valid = 1'b0;
    check("bp_hit_clr", {63'd0, bp_hit}, 64'd0);
    #1 check("bp_skip_en", {63'd0, cpu_en}, 64'd1);
    cyc(); pc = 32'h44;
    #1 check("bp_continue", {63'd0, cpu_en}, 64'd1);
    cyc(); pc = 32'h48;
    cmd(2'b00, 16'd0);
    cyc();
    cmd_valid = 1'b0;
    cyc();

    // core_halt_req and breakpoint in the same cycle
    pc = 32'h3C;
    cmd(2'b01, 16'd0);
    cyc();
    cmd_valid = 1'b0;
    cyc(); pc = 32'h40; core_halt_req = 1'b1;
    #1 check("core_bp_en", {63'd0, cpu_en}, 64'd0);
    cyc();
    check("core_flag", {63'd0, core_halted}, 64'd1);
    check("core_no_bp", {63'd0, bp_hit}, 64'd0);
    // Held halt request: RUN accepted but core never advances
    bp_enable = 1'b0;
    cmd(2'b01, 16'd0);
    cyc();
    cmd_valid = 1'b0;
    check("held_state_run", {62'd0, state}, 64'd1);
    #1 check("held_en", {63'd0, cpu_en}, 64'd0);
    cyc();
    check("held_rehalt", {62'd0, state}, 64'd0);
    check("held_done", {63'd0, done_pulse}, 64'd1);
    core_halt_req = 1'b0;

    // RUN is held off while stepping
    cmd(2'b10, 16'd5);
    cyc();
    cmd(2'b01, 16'd0);
    #1 check("run_in_step_ready", {63'd0, cmd_ready}, 64'd0);
    cyc();
    cmd_valid = 1'b0;
    check("run_in_step_state", {62'd0, state}, 64'd2);
    check("run_in_step_left", {48'd0, steps_left}, 64'd4);
    n = 0;
    while (m_mode != 0 && n < 20) begin cyc(); n++; end
    check("step5_drain", 64'(n), 64'd4);
    cyc();

    // Counter wrap from all-ones
    force dut.u_cnt.count_r = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1 release dut.u_cnt.count_r;
    cmd(2'b10, 16'd1);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    check("wrap_zero", {32'd0, cycle_count}, 64'd0);

    // Set a breakpoint flag, then CLEAR
    bp_enable = 1'b1; pc = 32'h3C;
    cmd(2'b01, 16'd0);
    cyc();
    cmd_valid = 1'b0;
    cyc(); pc = 32'h40;
    cyc();
    check("pre_clear_bp", {63'd0, bp_hit}, 64'd1);
    cmd(2'b11, 16'd0);
    cyc();
    cmd_valid = 1'b0;
    check("clear_count", {32'd0, cycle_count}, 64'd0);
    check("clear_bp", {63'd0, bp_hit}, 64'd0);
    cyc();

    // Asynchronous reset in the middle of a STEP
    bp_enable = 1'b0; pc = 32'h100;
    cmd(2'b10, 16'd10);
    cyc();
    cmd_valid = 1'b0;
    repeat (3) cyc();
    check("mid_step_left7", {48'd0, steps_left}, 64'd7);
    #1 check("mid_step_en", {63'd0, cpu_en}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_en", {63'd0, cpu_en}, 64'd0);
    check("arst_state", {62'd0, state}, 64'd0);
    check("arst_left", {48'd0, steps_left}, 64'd0);
    check("arst_count", {32'd0, cycle_count}, 64'd0);
    check("arst_flags", {62'd0, bp_hit, core_halted}, 64'd0);
    check("arst_done", {63'd0, done_pulse}, 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
